// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads imem, issues words to cpu over valid/ready.
// Optional return-stack guard: define RS_GUARD_EN to fault-halt on stack overflow/underflow.
module instr_fetch #(
  parameter int WIDTH_DATA = 16,
  parameter int PC_WIDTH   = 11,
  parameter int RS_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  imem_en,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [WIDTH_DATA-1:0] imem_rdata,
  output logic [WIDTH_DATA-1:0] instruction,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  halted,
  output logic                  fault
);
  localparam int SPW = $clog2(RS_DEPTH) + 1;
  localparam int IW  = SPW - 1;

  localparam logic [4:0] OP_CALL = 5'd20;
  localparam logic [4:0] OP_RET  = 5'd21;
  localparam logic [4:0] OP_JMP  = 5'd22;
  localparam logic [4:0] OP_HALT = 5'd31;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, HALT} state_t;

  state_t              state, state_nx;
  logic [PC_WIDTH-1:0] fpc, fpc_nx;
  logic [SPW-1:0]      sp, sp_nx, sp_dec;
  logic [PC_WIDTH-1:0] stack [RS_DEPTH];
  logic [4:0]          op;
  logic [PC_WIDTH-1:0] imm, pc_inc, top;
  logic                push, fault_set, ovf, udf;

  assign op     = instruction[WIDTH_DATA-1 -: 5];
  assign imm    = instruction[PC_WIDTH-1:0];
  assign pc_inc = pc + 1'b1;
  assign sp_dec = sp - 1'b1;
  assign top    = stack[sp_dec[IW-1:0]];

`ifdef RS_GUARD_EN
  assign ovf = (sp == SPW'(RS_DEPTH));
  assign udf = (sp == '0);
`else
  // unguarded: index simply wraps mod RS_DEPTH
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  assign imem_addr = fpc;
  assign halted    = (state == HALT);

  always_comb begin
    state_nx    = state;
    fpc_nx      = fpc;
    sp_nx       = sp;
    push        = 1'b0;
    fault_set   = 1'b0;
    imem_en     = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE:  if (run) state_nx = FETCH;
      FETCH: begin
        imem_en  = 1'b1;
        state_nx = WAIT;
      end
      WAIT:  state_nx = ISSUE;
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_nx = FETCH;
          case (op)
            OP_CALL: begin
              if (ovf) begin
                fault_set = 1'b1;
                state_nx  = HALT;
              end else begin
                push   = 1'b1;
                sp_nx  = sp + 1'b1;
                fpc_nx = imm;
              end
            end
            OP_RET: begin
              if (udf) begin
                fault_set = 1'b1;
                state_nx  = HALT;
              end else begin
                sp_nx  = sp_dec;
                fpc_nx = top;
              end
            end
            OP_JMP:  fpc_nx = imm;
            OP_HALT: state_nx = HALT;
            default: fpc_nx = pc_inc;
          endcase
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fpc         <= '0;
      sp          <= '0;
      pc          <= '0;
      instruction <= '0;
      fault       <= 1'b0;
    end else begin
      state <= state_nx;
      fpc   <= fpc_nx;
      sp    <= sp_nx;
      if (state == WAIT) begin
        instruction <= imem_rdata;
        pc          <= fpc;
      end
      if (fault_set) fault <= 1'b1;
    end
  end

  // stack storage needs no reset; sp alone defines what is live
  always_ff @(posedge clk) begin
    if (push) stack[sp[IW-1:0]] <= pc_inc;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, directed sequences, random programs vs a
// program-level interpreter model.
module tb_instr_fetch;
  logic        clk, reset, run, imem_en, instr_valid, instr_ready, halted, fault;
  logic [10:0] imem_addr, pc;
  logic [15:0] imem_rdata, instruction;
  logic [15:0] mem [2048];

`ifdef RS_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  instr_fetch #(.WIDTH_DATA(16), .PC_WIDTH(11), .RS_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .run(run), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .halted(halted), .fault(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // program-level model: PC, return stack as plain array with modular index
  int mpc, msp;
  int mstk [8];
  bit mwr [8];
  int got [$];

  function automatic int m8(input int x);
    return ((x % 8) + 8) % 8;
  endfunction

  task automatic model_init();
    mpc = 0; msp = 0;
    for (int i = 0; i < 8; i++) begin mstk[i] = 0; mwr[i] = 1'b0; end
  endtask

  task automatic model_step(input logic [15:0] w, output bit hlt, output bit flt, output bit unk);
    int imm, idx;
    imm = int'(w[10:0]);
    hlt = 1'b0; flt = 1'b0; unk = 1'b0;
    case (w[15:11])
      5'd20: if (GUARD && msp == 8) begin hlt = 1'b1; flt = 1'b1; end
             else begin
               idx = m8(msp); mstk[idx] = (mpc + 1) % 2048; mwr[idx] = 1'b1;
               msp++; mpc = imm;
             end
      5'd21: if (GUARD && msp == 0) begin hlt = 1'b1; flt = 1'b1; end
             else begin
               idx = m8(msp - 1);
               if (!mwr[idx]) unk = 1'b1;
               mpc = mstk[idx]; msp--;
             end
      5'd22: mpc = imm;
      5'd31: hlt = 1'b1;
      default: mpc = (mpc + 1) % 2048;
    endcase
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; instr_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1; @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!instr_valid && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_valid_timeout"}, 32'(instr_valid), 1);
  endtask

  // run a loaded program, checking every issued word against the model
  task automatic run_prog(input int max_x, input bit rnd);
    int xf = 0, cyc = 0;
    bit done = 1'b0, h, f, u;
    got.delete();
    model_init();
    pulse_run();
    while (!done) begin
      instr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (instr_valid && instr_ready) begin
        chk("issue_pc", 32'(pc), 32'(mpc));
        chk("issue_instr", 32'(instruction), 32'(mem[mpc]));
        got.push_back(int'(pc));
        model_step(mem[mpc], h, f, u);
        xf++;
        if (h) begin
          @(negedge clk);
          chk("halted_after", 32'(halted), 1);
          chk("fault_after", 32'(fault), 32'(f));
          chk("imem_en_halt", 32'(imem_en), 0);
          repeat (3) begin
            @(negedge clk);
            chk("no_valid_in_halt", 32'(instr_valid), 0);
          end
          done = 1'b1;
        end else if (u || xf >= max_x) done = 1'b1;
      end else if (cyc > 3000) begin
        chk("run_timeout", 0, 1);
        done = 1'b1;
      end
      if (!done) begin @(negedge clk); cyc++; end
    end
    instr_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] w0;
    logic [10:0] a1;
    logic [15:0] w1;
    int          nx;
    bit          ehalt;
    bit          efault;
    logic [10:0] eaddr;
    string       nm;
  } vec_t;
  vec_t tv [9];

  initial begin
    tv[0] = '{16'h0805, 11'd0,    16'h0000, 1, 1'b0, 1'b0, 11'd1,    "plain_inc"};
    tv[1] = '{16'hB007, 11'd0,    16'h0000, 1, 1'b0, 1'b0, 11'd7,    "jmp7"};
    tv[2] = '{16'hB7FF, 11'd0,    16'h0000, 1, 1'b0, 1'b0, 11'd2047, "jmp2047"};
    tv[3] = '{16'hA009, 11'd0,    16'h0000, 1, 1'b0, 1'b0, 11'd9,    "call9"};
    tv[4] = '{16'hF800, 11'd0,    16'h0000, 1, 1'b1, 1'b0, 11'd0,    "halt"};
    tv[5] = '{16'hB7FF, 11'd2047, 16'h0800, 2, 1'b0, 1'b0, 11'd0,    "wrap"};
    tv[6] = '{16'h0000, 11'd0,    16'h0000, 1, 1'b0, 1'b0, 11'd1,    "op0"};
    tv[7] = '{16'hA00A, 11'd10,   16'hA800, 2, 1'b0, 1'b0, 11'd1,    "call_ret"};
`ifdef RS_GUARD_EN
    tv[8] = '{16'hA800, 11'd0,    16'h0000, 1, 1'b1, 1'b1, 11'd0,    "ret_empty"};
`else
    tv[8] = '{16'h5123, 11'd0,    16'h0000, 1, 1'b0, 1'b0, 11'd1,    "op10"};
`endif

    // reset state
    clr_mem();
    reset = 1'b1; run = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_imem_en", 32'(imem_en), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    @(negedge clk);
    reset = 1'b0;

    // first fetch latency and stall stability
    mem[0] = 16'h0805;
    pulse_run();
    chk("first_imem_en", 32'(imem_en), 1);
    chk("first_imem_addr", 32'(imem_addr), 0);
    @(negedge clk);
    chk("wait_no_valid", 32'(instr_valid), 0);
    @(negedge clk);
    chk("lat_valid", 32'(instr_valid), 1);
    chk("lat_instr", 32'(instruction), 32'h0805);
    chk("lat_pc", 32'(pc), 0);
    repeat (4) begin
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_instr", 32'(instruction), 32'h0805);
      chk("stall_pc", 32'(pc), 0);
      chk("stall_no_fetch", 32'(imem_en), 0);
    end

    // vector table
    for (int i = 0; i < 9; i++) begin
      int n;
      clr_mem();
      mem[0] = tv[i].w0;
      if (tv[i].nx == 2) mem[tv[i].a1] = tv[i].w1;
      do_reset();
      pulse_run();
      for (int k = 0; k < tv[i].nx; k++) begin
        wait_valid(tv[i].nm);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
      end
      n = 0;
      while (!imem_en && !halted && n < 8) begin @(negedge clk); n++; end
      chk({tv[i].nm, "_halted"}, 32'(halted), 32'(tv[i].ehalt));
      chk({tv[i].nm, "_fault"}, 32'(fault), 32'(tv[i].efault));
      if (!tv[i].ehalt) chk({tv[i].nm, "_next_addr"}, 32'(imem_addr), 32'(tv[i].eaddr));
    end

    // CALL 3 / RET / JMP 7 / HALT
    clr_mem();
    mem[0] = 16'hA003; mem[3] = 16'hA800; mem[1] = 16'hB007; mem[7] = 16'hF800;
    do_reset();
    run_prog(20, 1'b0);
    chk("seq_len", 32'(got.size()), 4);
    if (got.size() == 4) begin
      chk("seq0", 32'(got[0]), 0); chk("seq1", 32'(got[1]), 3);
      chk("seq2", 32'(got[2]), 1); chk("seq3", 32'(got[3]), 7);
    end

    // nested calls
    clr_mem();
    mem[0] = 16'hA004; mem[4] = 16'hA008; mem[8] = 16'hA00C;
    mem[12] = 16'hA800; mem[9] = 16'hA800; mem[5] = 16'hA800; mem[1] = 16'hF800;
    do_reset();
    run_prog(20, 1'b1);
    chk("nest_len", 32'(got.size()), 7);
    if (got.size() == 7) begin
      chk("nest_ret9", 32'(got[4]), 9); chk("nest_ret5", 32'(got[5]), 5);
      chk("nest_ret1", 32'(got[6]), 1);
    end
    chk("nest_sp0", 32'(dut.sp), 0);

    // RS_DEPTH+1 consecutive calls
    clr_mem();
    for (int i = 0; i < 9; i++) mem[i] = 16'hA000 | 16'(i + 1);
    mem[9] = 16'hF800;
    do_reset();
    run_prog(20, 1'b0);
    chk("deep_len", 32'(got.size()), GUARD ? 9 : 10);
    chk("deep_fault", 32'(fault), 32'(GUARD));

    // reset asserted while issuing
    clr_mem();
    mem[0] = 16'h0805;
    do_reset();
    pulse_run();
    wait_valid("midrst");
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(instr_valid), 0);
    chk("midrst_instr", 32'(instruction), 0);
    chk("midrst_pc", 32'(pc), 0);
    chk("midrst_halted", 32'(halted), 0);
    @(negedge clk);
    reset = 1'b0;
    pulse_run();
    chk("restart_en", 32'(imem_en), 1);
    chk("restart_addr", 32'(imem_addr), 0);

    // random programs in addresses 0..63, random backpressure
    for (int t = 0; t < 30; t++) begin
      clr_mem();
      for (int a = 0; a < 64; a++) begin
        int r;
        logic [4:0] o;
        r = $urandom_range(0, 99);
        if (r < 25)      mem[a] = {5'd20, 11'($urandom_range(0, 63))};
        else if (r < 45) mem[a] = {5'd21, 11'($urandom)};
        else if (r < 60) mem[a] = {5'd22, 11'($urandom_range(0, 63))};
        else if (r < 62) mem[a] = {5'd31, 11'($urandom)};
        else begin
          o = 5'($urandom);
          if (o == 5'd20 || o == 5'd21 || o == 5'd22 || o == 5'd31) o = 5'd1;
          mem[a] = {o, 11'($urandom)};
        end
      end
      mem[64] = 16'hF800;
      do_reset();
      run_prog(40, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
